regfile_wb_scheduler: RTL and testbench

- Schedules the single write port of the 32x32 register file between two writeback producers: ALU (source 0) and load unit (source 1).
- Round-robin arbitration with valid/ready handshakes.
- Registers the winning write onto the register-file write port.
- Keeps a pending-write scoreboard so decode can detect RAW and WAW hazards against outstanding writes.
- Sits between execute/memory stages, decode, and the register file.

---
 rtl/regfile_wb_scheduler.sv | 105 ++++++++++
 tb/tb_regfile_wb_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler: round-robin arbitration of the ALU and load unit onto
// the single write port, plus a pending-write scoreboard for decode hazard detection.
module regfile_wb_scheduler #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int RW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [RW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [RW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            wb_we,
  output logic [RW-1:0]   wb_rd,
  output logic [XLEN-1:0] wb_data,
  input  logic            alloc_valid,
  input  logic [RW-1:0]   alloc_rd,
  output logic            alloc_ready,
  input  logic [RW-1:0]   rs1,
  input  logic [RW-1:0]   rs2,
  output logic            raw_hazard
);

  // last_grant_reg: 0 = ALU won most recently, 1 = load unit won most recently
  logic            last_grant_reg;
  logic            wb_we_reg;
  logic [RW-1:0]   wb_rd_reg;
  logic [XLEN-1:0] wb_data_reg;
  logic [NREG-1:0] pending_reg;
  logic [NREG-1:0] pending_next;

  logic            grant_alu;
  logic            grant_lsu;
  logic            hs_any;
  logic [RW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            alloc_fire;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;

  always_comb begin
    grant_alu = alu_valid & (~lsu_valid | last_grant_reg);
    grant_lsu = lsu_valid & (~alu_valid | ~last_grant_reg);
    hs_any    = grant_alu | grant_lsu;
    sel_rd    = grant_alu ? alu_rd : lsu_rd;
    sel_data  = grant_alu ? alu_data : lsu_data;
  end

  assign alu_ready = grant_alu;
  assign lsu_ready = grant_lsu;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_reg <= 1'b1;
      wb_we_reg      <= 1'b0;
      wb_rd_reg      <= '0;
      wb_data_reg    <= '0;
    end else begin
      wb_we_reg <= hs_any & (sel_rd != '0);
      if (hs_any) begin
        last_grant_reg <= grant_lsu;
      end
      // x0 handshakes are consumed without disturbing the visible write port
      if (hs_any && sel_rd != '0) begin
        wb_rd_reg   <= sel_rd;
        wb_data_reg <= sel_data;
      end
    end
  end

  assign wb_we   = wb_we_reg;
  assign wb_rd   = wb_rd_reg;
  assign wb_data = wb_data_reg;

  always_comb begin
    alloc_ready = (alloc_rd == '0) | ~pending_reg[alloc_rd] | (wb_we_reg & (wb_rd_reg == alloc_rd));
    alloc_fire  = alloc_valid & alloc_ready & (alloc_rd != '0);
    set_vec     = alloc_fire ? (NREG'(1) << alloc_rd) : '0;
    clr_vec     = wb_we_reg ? (NREG'(1) << wb_rd_reg) : '0;
    raw_hazard  = ((rs1 != '0) & pending_reg[rs1]) | ((rs2 != '0) & pending_reg[rs2]);
  end

  // Set has priority over clear so an allocation landing on the retiring write stays pending
  for (genvar gi = 0; gi < NREG; gi++) begin : g_pending
    if (gi == 0) begin : g_x0
      assign pending_next[gi] = 1'b0;
    end else begin : g_reg
      assign pending_next[gi] = set_vec[gi] | (pending_reg[gi] & ~clr_vec[gi]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed self-checking bench for regfile_wb_scheduler: arbitration, write port timing,
// scoreboard hazards, x0 handling and asynchronous reset.
module tb_regfile_wb_scheduler;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic        alloc_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        raw_hazard;

  int checks;
  int errors;

  regfile_wb_scheduler #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready),
    .rs1(rs1), .rs2(rs2), .raw_hazard(raw_hazard)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #12;
    rs1 = 5'd7;
    #1;
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", wb_we); end
    checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d want 0", wb_rd); end
    checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", wb_data); end
    checks++; if (raw_hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got %b want 0", raw_hazard); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready got %b want 1", alloc_ready); end
    checks++; if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b want 00", alu_ready, lsu_ready); end
    rs1 = 5'd0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    $display("reset: released");
  endtask

  task automatic test_contention;
    logic ea [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic el [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic ew [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [4:0] er [4] = '{5'd3, 5'd4, 5'd4, 5'd4};
    logic ga, gl;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      ga = alu_ready; gl = lsu_ready;
      checks++; if (alu_ready !== ea[c] || lsu_ready !== el[c]) begin
        errors++; $display("FAIL contention_grant c%0d got %b%b want %b%b", c, alu_ready, lsu_ready, ea[c], el[c]);
      end
      tick();
      if (ga) alu_valid = 1'b0;
      if (gl) lsu_valid = 1'b0;
      checks++; if (wb_we !== ew[c] || (ew[c] && wb_rd !== er[c])) begin
        errors++; $display("FAIL contention_wb c%0d got we=%b rd=%0d want we=%b rd=%0d", c, wb_we, wb_rd, ew[c], er[c]);
      end
      $display("contention: cycle %0d grant alu=%b lsu=%b wb_we=%b wb_rd=%0d", c, ga, gl, wb_we, wb_rd);
    end
  endtask

  task automatic test_sustained;
    logic exp_alu;
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA0;
    lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 32'hB0;
    for (int c = 0; c < 6; c++) begin
      exp_alu = (c % 2 == 0);
      @(negedge clk);
      checks++; if (alu_ready !== exp_alu || lsu_ready !== ~exp_alu) begin
        errors++; $display("FAIL sustained_grant c%0d got %b%b want %b%b", c, alu_ready, lsu_ready, exp_alu, ~exp_alu);
      end
      tick();
      checks++; if (wb_we !== 1'b1 || wb_rd !== (exp_alu ? 5'd10 : 5'd11) || wb_data !== (exp_alu ? 32'hA0 : 32'hB0)) begin
        errors++; $display("FAIL sustained_wb c%0d got we=%b rd=%0d data=%h", c, wb_we, wb_rd, wb_data);
      end
      $display("sustained: cycle %0d wb_rd=%0d wb_data=%h", c, wb_rd, wb_data);
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    tick();
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL sustained_idle got %b want 0", wb_we); end
  endtask

  task automatic test_single;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin errors++; $display("FAIL single_ready got %b%b want 10", alu_ready, lsu_ready); end
    tick();
    alu_valid = 1'b0;
    checks++; if (wb_we !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_wb got we=%b rd=%0d data=%h want 1/5/deadbeef", wb_we, wb_rd, wb_data);
    end
    tick();
    checks++; if (wb_we !== 1'b0 || wb_rd !== 5'd5 || wb_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_hold got we=%b rd=%0d data=%h want 0/5/deadbeef", wb_we, wb_rd, wb_data);
    end
    $display("single: rd=5 data=deadbeef written");
  endtask

  task automatic test_hazard;
    alloc_valid = 1'b1; alloc_rd = 5'd7;
    @(negedge clk);
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL hazard_alloc1 got %b want 1", alloc_ready); end
    tick();
    rs1 = 5'd7;
    @(negedge clk);
    checks++; if (raw_hazard !== 1'b1) begin errors++; $display("FAIL hazard_raw got %b want 1", raw_hazard); end
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL hazard_waw got %b want 0", alloc_ready); end
    tick();
    alloc_valid = 1'b0;
    tick();
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
    @(negedge clk);
    checks++; if (lsu_ready !== 1'b1 || raw_hazard !== 1'b1) begin errors++; $display("FAIL hazard_lsu got ready=%b raw=%b want 1/1", lsu_ready, raw_hazard); end
    tick();
    lsu_valid = 1'b0;
    checks++; if (wb_we !== 1'b1 || wb_rd !== 5'd7) begin errors++; $display("FAIL hazard_wb got we=%b rd=%0d want 1/7", wb_we, wb_rd); end
    @(negedge clk);
    checks++; if (raw_hazard !== 1'b1) begin errors++; $display("FAIL hazard_nobypass got %b want 1", raw_hazard); end
    tick();
    checks++; if (raw_hazard !== 1'b0) begin errors++; $display("FAIL hazard_cleared got %b want 0", raw_hazard); end
    rs1 = 5'd0;
    $display("hazard: rd=7 allocated, written and cleared");
  endtask

  task automatic test_alloc_on_clear;
    alloc_valid = 1'b1; alloc_rd = 5'd9;
    tick();
    alloc_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99; rs2 = 5'd9;
    tick();
    alu_valid = 1'b0;
    alloc_valid = 1'b1; alloc_rd = 5'd9;
    @(negedge clk);
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL clear_alloc_ready got %b want 1", alloc_ready); end
    tick();
    alloc_valid = 1'b0;
    checks++; if (raw_hazard !== 1'b1) begin errors++; $display("FAIL clear_set_wins got %b want 1", raw_hazard); end
    alu_valid = 1'b1;
    tick();
    alu_valid = 1'b0;
    tick();
    checks++; if (raw_hazard !== 1'b0) begin errors++; $display("FAIL clear_final got %b want 0", raw_hazard); end
    rs2 = 5'd0;
    $display("alloc_on_clear: rd=9 re-allocated on its clear cycle");
  endtask

  task automatic test_x0;
    alloc_valid = 1'b1; alloc_rd = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    rs1 = 5'd0; rs2 = 5'd0;
    @(negedge clk);
    checks++; if (alloc_ready !== 1'b1 || alu_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got alloc=%b alu=%b want 1/1", alloc_ready, alu_ready); end
    tick();
    alloc_valid = 1'b0; alu_valid = 1'b0;
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL x0_we got %b want 0", wb_we); end
    @(negedge clk);
    checks++; if (raw_hazard !== 1'b0) begin errors++; $display("FAIL x0_hazard got %b want 0", raw_hazard); end
    $display("x0: write and alloc of x0 ignored");
  endtask

  task automatic test_async_reset;
    alloc_valid = 1'b1; alloc_rd = 5'd7;
    tick();
    alloc_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h70;
    tick();
    alu_valid = 1'b0; rs1 = 5'd7;
    #1;
    checks++; if (wb_we !== 1'b1 || raw_hazard !== 1'b1) begin errors++; $display("FAIL areset_pre got we=%b raw=%b want 1/1", wb_we, raw_hazard); end
    #1;
    rst = 1'b0;
    #1;
    checks++; if (wb_we !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0) begin
      errors++; $display("FAIL areset_wb got we=%b rd=%0d data=%h want 0/0/0", wb_we, wb_rd, wb_data);
    end
    checks++; if (raw_hazard !== 1'b0) begin errors++; $display("FAIL areset_pending got %b want 0", raw_hazard); end
    @(negedge clk);
    rst = 1'b1;
    rs1 = 5'd0;
    tick();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
    @(negedge clk);
    checks++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin errors++; $display("FAIL areset_grant got %b%b want 10", alu_ready, lsu_ready); end
    tick();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    checks++; if (wb_we !== 1'b1 || wb_rd !== 5'd3) begin errors++; $display("FAIL areset_wb_after got we=%b rd=%0d want 1/3", wb_we, wb_rd); end
    tick();
    $display("async_reset: mid-cycle reset cleared state, ALU won first conflict");
  endtask

  initial begin
    checks = 0; errors = 0;
    clk = 1'b0; rst = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    alloc_valid = 1'b0; alloc_rd = '0;
    rs1 = '0; rs2 = '0;
    test_reset();
    test_contention();
    test_sustained();
    test_single();
    test_hazard();
    test_alloc_on_clear();
    test_x0();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
